countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter SIZE, default 8, giving the count width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port load_valid  input  1  request to load a new count.
REQ-005 SHALL have port load_value  input  SIZE  start count, sampled on load accept.
REQ-006 SHALL have port load_ready  output  1  block can accept a load this cycle.
REQ-007 SHALL have port auto_reload  input  1  periodic mode flag, sampled on load accept.
REQ-008 SHALL have port pause  input  1  level; freezes the count while high.
REQ-009 SHALL have port abort  input  1  synchronous cancel of the current count.
REQ-010 SHALL have port ctr  output  SIZE  current count value, registered.
REQ-011 SHALL have port busy  output  1  high while state is RUN.
REQ-012 SHALL have port done  output  1  one-cycle terminal-count pulse, registered.

Function
REQ-013 SHALL implement the states IDLE, RUN and DONE.
REQ-014 SHALL drive load_ready high in IDLE and DONE, and low in RUN.
REQ-015 SHALL accept a load on a rising edge where load_valid and load_ready are both high, with no partial or queued loads.
REQ-016 On accepting load N>0, SHALL set ctr=N, latch N and auto_reload internally, and enter RUN at that edge.
REQ-017 On accepting load N=0, SHALL leave ctr=0, enter DONE and assert done for the following cycle; auto_reload is ignored.
REQ-018 In RUN with pause low, SHALL decrement ctr by 1 per edge.
REQ-019 In RUN with pause high, SHALL hold ctr unchanged and keep busy high, with no done.
REQ-020 On the edge where ctr goes 1->0, SHALL set done=1 for exactly one cycle, so done follows the accept edge by N edges when unpaused.
REQ-021 With auto_reload latched: on the edge after ctr reaches 0, SHALL reload ctr=N and stay in RUN, giving a period of N+1 cycles.
REQ-022 Without auto_reload: on the edge after ctr reaches 0, SHALL enter DONE, where ctr holds 0 until a new load is accepted or abort is asserted.
REQ-023 SHALL never decrement below 0, with no wrap to all-ones.
REQ-024 SHALL give abort the highest non-reset priority: on that edge ctr=0, state=IDLE, done=0, auto_reload cleared, and any simultaneous load is not accepted.
REQ-025 SHALL let pause take priority over terminal detection: a ctr of 1 held by pause produces no done.
REQ-026 SHALL accept a load arriving in DONE in the same cycle done is high, with the new count starting normally.
REQ-027 SHALL treat load_value and auto_reload as don't-care when no load is accepted.

Reset
REQ-028 While rst=0, SHALL force ctr=0, done=0, busy=0, load_ready=0 and state=IDLE, independent of clk.
REQ-029 SHALL assert load_ready on the first rising edge after rst releases, and ignore load_valid before that edge.
REQ-030 A reset asserted mid-count SHALL discard the latched reload value, with no done pulse generated.

Structure
REQ-031 SHALL place the state encoding (IDLE/RUN/DONE enum) and the default SIZE constant in the shared package countdown_timer_pkg.
REQ-032 SHALL be one flat module with no sub-module: one state register, one count register, one reload register, and a registered done.

Verification
REQ-033 Bench SHALL cover: SIZE=8, load 5, auto_reload=0 -> ctr 5,4,3,2,1,0; done high exactly 1 cycle, 5 edges after accept; then DONE with load_ready=1 and ctr=0.
REQ-034 Bench SHALL cover: load 3, auto_reload=1, run 12 cycles -> ctr 3,2,1,0,3,2,1,0,3...; done pulses every 4 cycles; busy stays high.
REQ-035 Bench SHALL cover: load 4, pause high for 3 cycles when ctr=2 -> ctr holds 2 for 3 cycles; done is delayed 3 cycles and still lasts 1 cycle.
REQ-036 Bench SHALL cover: load 200, abort when ctr=150 while load_valid is also high -> ctr=0, state IDLE, no done, load not taken; next load 7 is accepted.
REQ-037 Bench SHALL cover: load 0 -> done high 1 cycle after accept, ctr stays 0, busy never high.
REQ-038 Bench SHALL cover: load 255 with rst pulsed low asynchronously (between clk edges) at ctr=100 -> ctr=0, done=0 and load_ready=0 immediately; load_ready=1 on the first edge after release.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg: shared state encoding and default width for countdown_timer
package countdown_timer_pkg;
  localparam int DEFAULT_SIZE = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with one-shot/periodic modes, pause and abort
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_valid,
  input  logic [SIZE-1:0] load_value,
  output logic            load_ready,
  input  logic            auto_reload,
  input  logic            pause,
  input  logic            abort,
  output logic [SIZE-1:0] ctr,
  output logic            busy,
  output logic            done
);
  state_e state_q, state_d;
  logic [SIZE-1:0] ctr_q, ctr_d, reload_q, reload_d;
  logic auto_q, auto_d, done_q, done_d, armed_q;
  logic accept;

  // armed_q keeps load_ready low until the first edge after reset release
  assign load_ready = armed_q && (state_q != RUN);
  assign accept = load_valid && load_ready && !abort;
  assign ctr = ctr_q;
  assign busy = state_q == RUN;
  assign done = done_q;

  // next state: abort beats load, load beats counting, pause freezes RUN entirely
  always_comb begin
    state_d = state_q;
    ctr_d = ctr_q;
    reload_d = reload_q;
    auto_d = auto_q;
    done_d = 1'b0;
    if (abort) begin
      state_d = IDLE;
      ctr_d = '0;
      auto_d = 1'b0;
    end else if (accept) begin
      ctr_d = load_value;
      reload_d = load_value;
      state_d = (load_value == '0) ? DONE : RUN;
      done_d = load_value == '0;
      auto_d = (load_value != '0) && auto_reload;
    end else if (state_q == RUN && !pause) begin
      if (ctr_q != '0) begin
        ctr_d = ctr_q - SIZE'(1);
        done_d = ctr_q == SIZE'(1);
      end else if (auto_q) begin
        ctr_d = reload_q;
      end else begin
        state_d = DONE;
      end
    end
  end

  // state, count, reload and done registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ctr_q <= '0;
      reload_q <= '0;
      auto_q <= 1'b0;
      done_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q <= ctr_d;
      reload_q <= reload_d;
      auto_q <= auto_d;
      done_q <= done_d;
      armed_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed scoreboard bench for countdown_timer
module tb_countdown_timer;
  logic clk = 1'b0;
  logic rst, load_valid, auto_reload, pause, abort;
  logic [7:0] load_value, ctr;
  logic load_ready, busy, done;

  typedef struct {
    string tag;
    logic [7:0] ctr;
    logic busy;
    logic done;
    logic rdy;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int ar_seq[12] = '{2, 1, 0, 3, 2, 1, 0, 3, 2, 1, 0, 3};

  countdown_timer #(.SIZE(8)) dut (
    .clk(clk),
    .rst(rst),
    .load_valid(load_valid),
    .load_value(load_value),
    .load_ready(load_ready),
    .auto_reload(auto_reload),
    .pause(pause),
    .abort(abort),
    .ctr(ctr),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic void check(string tag, string what, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0d expected %0d", tag, what, got, exp);
    end
  endfunction

  function automatic void push(string tag, int c, bit b, bit d, bit r);
    exp_t e;
    e.tag = tag;
    e.ctr = 8'(c);
    e.busy = b;
    e.done = d;
    e.rdy = r;
    q.push_back(e);
  endfunction

  task automatic step(string tag, int c, bit b, bit d, bit r);
    @(posedge clk);
    #1;
    push(tag, c, b, d, r);
  endtask

  task automatic check_now(string tag, int c, bit b, bit d, bit r);
    check(tag, "ctr", 32'(ctr), 32'(c));
    check(tag, "busy", 32'(busy), 32'(b));
    check(tag, "done", 32'(done), 32'(d));
    check(tag, "load_ready", 32'(load_ready), 32'(r));
  endtask

  // monitor: one expected record per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check(e.tag, "ctr", 32'(ctr), 32'(e.ctr));
      check(e.tag, "busy", 32'(busy), 32'(e.busy));
      check(e.tag, "done", 32'(done), 32'(e.done));
      check(e.tag, "load_ready", 32'(load_ready), 32'(e.rdy));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    load_valid = 1'b1;
    load_value = 8'd9;
    auto_reload = 1'b0;
    pause = 1'b0;
    abort = 1'b0;
    #1;
    check_now("reset_now", 0, 0, 0, 0);
    push("reset", 0, 0, 0, 0);
    #11;
    rst = 1'b1;
    step("first_edge_ignores_load", 0, 0, 0, 1);
    load_valid = 1'b0;
    step("idle", 0, 0, 0, 1);

    load_valid = 1'b1;
    load_value = 8'd5;
    step("oneshot_accept", 5, 1, 0, 0);
    load_valid = 1'b0;
    for (int i = 4; i >= 1; i--) step("oneshot_count", i, 1, 0, 0);
    step("oneshot_done", 0, 1, 1, 0);
    step("oneshot_enter_done", 0, 0, 0, 1);
    step("oneshot_hold", 0, 0, 0, 1);

    load_valid = 1'b1;
    load_value = 8'd3;
    auto_reload = 1'b1;
    step("auto_accept", 3, 1, 0, 0);
    load_valid = 1'b0;
    auto_reload = 1'b0;
    for (int i = 0; i < 12; i++) step("auto_run", ar_seq[i], 1, ar_seq[i] == 0, 0);
    abort = 1'b1;
    step("auto_abort", 0, 0, 0, 1);
    abort = 1'b0;

    load_valid = 1'b1;
    load_value = 8'd4;
    step("pause_accept", 4, 1, 0, 0);
    load_valid = 1'b0;
    step("pause_count", 3, 1, 0, 0);
    step("pause_count", 2, 1, 0, 0);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) step("pause_hold", 2, 1, 0, 0);
    pause = 1'b0;
    step("pause_resume", 1, 1, 0, 0);
    step("pause_done", 0, 1, 1, 0);
    step("pause_enter_done", 0, 0, 0, 1);

    load_valid = 1'b1;
    load_value = 8'd200;
    step("abort_accept", 200, 1, 0, 0);
    load_valid = 1'b0;
    for (int i = 1; i <= 50; i++) step("abort_count", 200 - i, 1, 0, 0);
    abort = 1'b1;
    load_valid = 1'b1;
    load_value = 8'd77;
    auto_reload = 1'b1;
    step("abort_beats_load", 0, 0, 0, 1);
    abort = 1'b0;
    load_value = 8'd7;
    auto_reload = 1'b0;
    step("after_abort_accept", 7, 1, 0, 0);
    load_valid = 1'b0;
    for (int i = 6; i >= 1; i--) step("after_abort_count", i, 1, 0, 0);
    step("after_abort_done", 0, 1, 1, 0);
    step("after_abort_enter_done", 0, 0, 0, 1);

    load_valid = 1'b1;
    load_value = 8'd0;
    auto_reload = 1'b1;
    step("zero_load", 0, 0, 1, 1);
    load_value = 8'd2;
    auto_reload = 1'b0;
    step("load_during_done", 2, 1, 0, 0);
    load_valid = 1'b0;
    step("load_during_done_count", 1, 1, 0, 0);
    step("load_during_done_done", 0, 1, 1, 0);
    step("load_during_done_idle", 0, 0, 0, 1);

    load_valid = 1'b1;
    load_value = 8'd255;
    auto_reload = 1'b1;
    step("rst_accept", 255, 1, 0, 0);
    load_valid = 1'b0;
    auto_reload = 1'b0;
    for (int i = 1; i <= 155; i++) step("rst_count", 255 - i, 1, 0, 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_now("async_reset_now", 0, 0, 0, 0);
    push("async_reset_held", 0, 0, 0, 0);
    load_valid = 1'b1;
    load_value = 8'd9;
    @(posedge clk);
    #2;
    rst = 1'b1;
    step("release_first_edge", 0, 0, 0, 1);
    load_value = 8'd2;
    step("post_reset_accept", 2, 1, 0, 0);
    load_valid = 1'b0;
    step("post_reset_count", 1, 1, 0, 0);
    step("post_reset_done", 0, 1, 1, 0);
    step("post_reset_no_reload", 0, 0, 0, 1);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    check("drain", "pending", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
